// File: rtl/flit_32_pkt_arbiter_if.sv
// ---------------------------------------------------------------------------
// flit_32_pkt_arbiter_if
// Bundle of flit handshake signals around the packet arbiter.
//   in_flit_data   [NUM_PORTS*32] per-port flit data, port i at [32*i+31:32*i]
//   in_flit_valid  [NUM_PORTS]    per-port valid
//   in_flit_last   [NUM_PORTS]    per-port last-flit marker
//   in_flit_16     [NUM_PORTS]    per-port "lower 16 bits only" marker
//   in_flit_ready  [NUM_PORTS]    per-port ready (driven by the arbiter)
//   out_flit_data  [32]           muxed flit data towards the sink
//   out_flit_valid                muxed valid
//   out_flit_last                 muxed or forced last
//   out_flit_16                   muxed 16-bit marker
//   out_flit_ready                sink ready
//   grant          [NUM_PORTS]    one-hot owning port, 0 when idle
//   err_overlen                   one-cycle truncation pulse
// modport slave  : the arbiter side
// modport master : the environment side (sources and sink)
// ---------------------------------------------------------------------------
interface flit_32_pkt_arbiter_if #(
    parameter int NUM_PORTS = 2
);
    logic [NUM_PORTS*32-1:0] in_flit_data;
    logic [NUM_PORTS-1:0]    in_flit_valid;
    logic [NUM_PORTS-1:0]    in_flit_last;
    logic [NUM_PORTS-1:0]    in_flit_16;
    logic [NUM_PORTS-1:0]    in_flit_ready;
    logic [31:0]             out_flit_data;
    logic                    out_flit_valid;
    logic                    out_flit_last;
    logic                    out_flit_16;
    logic                    out_flit_ready;
    logic [NUM_PORTS-1:0]    grant;
    logic                    err_overlen;

    modport slave (
        input  in_flit_data, in_flit_valid, in_flit_last, in_flit_16, out_flit_ready,
        output in_flit_ready, out_flit_data, out_flit_valid, out_flit_last, out_flit_16,
        output grant, err_overlen
    );

    modport master (
        output in_flit_data, in_flit_valid, in_flit_last, in_flit_16, out_flit_ready,
        input  in_flit_ready, out_flit_data, out_flit_valid, out_flit_last, out_flit_16,
        input  grant, err_overlen
    );
endinterface

// File: rtl/flit_32_pkt_arbiter.sv
// ---------------------------------------------------------------------------
// flit_32_pkt_arbiter
// Packet-level round-robin arbiter sharing one 32-bit flit sink between
// NUM_PORTS flit sources. A grant is held from first to last flit. Packets
// longer than MAX_PKT_LEN are cut: the MAX_PKT_LEN-th flit is forwarded as
// last, err_overlen pulses, and the rest of the packet is drained silently.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  flit_32_pkt_arbiter_if.slave (all flit handshakes, grant, error)
// ---------------------------------------------------------------------------
module flit_32_pkt_arbiter #(
    parameter int NUM_PORTS   = 2,
    parameter int MAX_PKT_LEN = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    flit_32_pkt_arbiter_if.slave        bus
);
    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CNT_W = $clog2(MAX_PKT_LEN + 1);
    localparam logic [PTR_W-1:0] LAST_PORT = PTR_W'(NUM_PORTS - 1);
    localparam logic [CNT_W-1:0] CNT_CAP   = CNT_W'(MAX_PKT_LEN - 1);
    localparam logic [PTR_W:0]   PORTS_EXT = (PTR_W + 1)'(NUM_PORTS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t               state_r, state_n;
    logic [NUM_PORTS-1:0] grant_r, grant_n;
    logic [PTR_W-1:0]     gidx_r, gidx_n;
    logic [PTR_W-1:0]     ptr_r, ptr_n;
    logic [CNT_W-1:0]     cnt_r, cnt_n;
    logic                 err_r, err_n;

    logic [PTR_W:0]       sum_s;
    logic [PTR_W-1:0]     cand_s;
    logic                 take_s;
    logic                 pick_found_s;
    logic [PTR_W-1:0]     pick_idx_s;
    logic [NUM_PORTS-1:0] pick_onehot_s;
    logic [PTR_W-1:0]     next_ptr_s;

    logic [31:0]          sel_data_s;
    logic                 sel_valid_s;
    logic                 sel_last_s;
    logic                 sel_16_s;
    logic                 at_cap_s;
    logic                 hs_s;

    // Cyclic search for the first requesting port, starting at the pointer.
    always_comb begin
        sum_s         = {(PTR_W + 1){1'b0}};
        cand_s        = {PTR_W{1'b0}};
        take_s        = 1'b0;
        pick_found_s  = 1'b0;
        pick_idx_s    = ptr_r;
        pick_onehot_s = {NUM_PORTS{1'b0}};
        for (int i = 0; i < NUM_PORTS; i++) begin
            sum_s        = {1'b0, ptr_r} + (PTR_W + 1)'(i);
            cand_s       = (sum_s >= PORTS_EXT) ? PTR_W'(sum_s - PORTS_EXT) : sum_s[PTR_W-1:0];
            take_s       = !pick_found_s && bus.in_flit_valid[cand_s];
            pick_idx_s   = take_s ? cand_s : pick_idx_s;
            pick_found_s = pick_found_s | take_s;
        end
        pick_onehot_s[pick_idx_s] = pick_found_s;
    end

    // AND-OR mux of the granted port's flit fields.
    always_comb begin
        sel_data_s  = 32'd0;
        sel_valid_s = 1'b0;
        sel_last_s  = 1'b0;
        sel_16_s    = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            sel_data_s  = sel_data_s  | ({32{gidx_r == PTR_W'(i)}} & bus.in_flit_data[i*32 +: 32]);
            sel_valid_s = sel_valid_s | ((gidx_r == PTR_W'(i)) & bus.in_flit_valid[i]);
            sel_last_s  = sel_last_s  | ((gidx_r == PTR_W'(i)) & bus.in_flit_last[i]);
            sel_16_s    = sel_16_s    | ((gidx_r == PTR_W'(i)) & bus.in_flit_16[i]);
        end
    end

    assign at_cap_s   = (cnt_r == CNT_CAP);
    assign next_ptr_s = (gidx_r == LAST_PORT) ? {PTR_W{1'b0}} : (gidx_r + PTR_W'(1));

    // Next-state logic: arbitration, packet tracking and truncation.
    always_comb begin
        state_n = state_r;
        grant_n = grant_r;
        gidx_n  = gidx_r;
        ptr_n   = ptr_r;
        cnt_n   = cnt_r;
        err_n   = 1'b0;
        hs_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pick_found_s) begin
                    state_n = ST_XFER;
                    gidx_n  = pick_idx_s;
                    grant_n = pick_onehot_s;
                    cnt_n   = {CNT_W{1'b0}};
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_XFER: begin
                hs_s = sel_valid_s & bus.out_flit_ready;
                if (hs_s && sel_last_s) begin
                    // Genuine last, including an exactly full-length packet.
                    state_n = ST_IDLE;
                    grant_n = {NUM_PORTS{1'b0}};
                    ptr_n   = next_ptr_s;
                end else if (hs_s && at_cap_s) begin
                    // Flit was sent with a forced last; drain the remainder.
                    state_n = ST_DROP;
                    err_n   = 1'b1;
                end else if (hs_s) begin
                    cnt_n = cnt_r + CNT_W'(1);
                end else begin
                    state_n = ST_XFER;
                end
            end
            ST_DROP: begin
                hs_s = sel_valid_s;
                if (hs_s && sel_last_s) begin
                    state_n = ST_IDLE;
                    grant_n = {NUM_PORTS{1'b0}};
                    ptr_n   = next_ptr_s;
                end else begin
                    state_n = ST_DROP;
                end
            end
            default: begin
                state_n = ST_IDLE;
                grant_n = {NUM_PORTS{1'b0}};
            end
        endcase
    end

    // State and bookkeeping registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            grant_r <= {NUM_PORTS{1'b0}};
            gidx_r  <= {PTR_W{1'b0}};
            ptr_r   <= {PTR_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            err_r   <= 1'b0;
        end else begin
            state_r <= state_n;
            grant_r <= grant_n;
            gidx_r  <= gidx_n;
            ptr_r   <= ptr_n;
            cnt_r   <= cnt_n;
            err_r   <= err_n;
        end
    end

    // Flit path outputs; everything is quiet outside XFER/DROP.
    always_comb begin
        bus.out_flit_data  = 32'd0;
        bus.out_flit_valid = 1'b0;
        bus.out_flit_last  = 1'b0;
        bus.out_flit_16    = 1'b0;
        bus.in_flit_ready  = {NUM_PORTS{1'b0}};
        case (state_r)
            ST_XFER: begin
                bus.out_flit_data  = sel_data_s;
                bus.out_flit_valid = sel_valid_s;
                bus.out_flit_last  = sel_last_s | at_cap_s;
                bus.out_flit_16    = sel_16_s;
                bus.in_flit_ready  = grant_r & {NUM_PORTS{bus.out_flit_ready}};
            end
            ST_DROP: begin
                // Accept and discard the tail of a truncated packet.
                bus.in_flit_ready = grant_r;
            end
            default: begin
                bus.in_flit_ready = {NUM_PORTS{1'b0}};
            end
        endcase
    end

    assign bus.grant       = grant_r;
    assign bus.err_overlen = err_r;

endmodule

// File: tb/tb_flit_32_pkt_arbiter.sv
// ---------------------------------------------------------------------------
// tb_flit_32_pkt_arbiter
// Self-checking bench for flit_32_pkt_arbiter. Sources are per-port flit
// queues; a cycle-level reference predicts grant/ready/flit outputs, and a
// packet-level expectation (truncated per-port streams, error counts,
// grant order) is built independently when packets are queued.
// ---------------------------------------------------------------------------
module tb_flit_32_pkt_arbiter;
    localparam int N    = 2;
    localparam int MAXL = 10;
    localparam int OW   = 2*N + 36;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic        f16;
    } flit_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    flit_32_pkt_arbiter_if #(.NUM_PORTS(N)) bus ();
    flit_32_pkt_arbiter #(.NUM_PORTS(N), .MAX_PKT_LEN(MAXL)) dut (.clk(clk), .rst(rst), .bus(bus));

    flit_t          fq     [N][$];
    flit_t          exp_pp [N][$];
    flit_t          seen[$];
    int             seen_port[$];
    logic [N-1:0]   grant_log[$];
    logic [N-1:0]   prev_grant;

    bit [N-1:0]     gate;
    bit             ready_drv;
    bit             rst_drv;
    bit [N-1:0]     drv_valid;
    logic [N-1:0]   exp_rdy;

    bit             m_busy, m_drop, m_err;
    int             m_owner, m_cnt, m_ptr;

    int             cyc_mism;
    logic [OW-1:0]  first_obs, first_exp;
    time            first_t;
    int             err_cnt;
    bit             drain_to;
    int             drain_steps;
    int             checks, passed;

    // Queue a packet and record what the sink should receive from it.
    task automatic push_pkt(input int p, input int len, input logic [31:0] first,
                            input logic [31:0] stride, input logic [31:0] f16_bits);
        flit_t f;
        for (int i = 0; i < len; i++) begin
            f.data = first + stride * 32'(i);
            f.last = (i == len - 1);
            f.f16  = f16_bits[i % 32];
            fq[p].push_back(f);
            if (i < MAXL) begin
                f.last = (i == len - 1) || (i == MAXL - 1);
                exp_pp[p].push_back(f);
            end
        end
    endtask

    task automatic clear_logs();
        seen.delete();
        seen_port.delete();
        grant_log.delete();
        err_cnt    = 0;
        cyc_mism   = 0;
        prev_grant = '0;
    endtask

    // Reference update at a clock edge, from the values driven before it.
    task automatic advance();
        bit    nerr;
        int    p;
        flit_t f;
        nerr = 1'b0;
        if (rst_drv) begin
            m_busy = 0; m_drop = 0; m_owner = 0; m_cnt = 0; m_ptr = 0; m_err = 0;
            return;
        end
        if (!m_busy) begin
            for (int i = 0; i < N; i++) begin
                p = (m_ptr + i) % N;
                if (!m_busy && drv_valid[p]) begin
                    m_busy = 1; m_owner = p; m_cnt = 0; m_drop = 0;
                end
            end
        end else if (drv_valid[m_owner] && exp_rdy[m_owner]) begin
            f = fq[m_owner].pop_front();
            if (f.last) begin
                m_busy = 0; m_drop = 0; m_ptr = (m_owner + 1) % N;
            end else if (!m_drop && m_cnt == MAXL - 1) begin
                m_drop = 1; nerr = 1;
            end
            m_cnt++;
        end
        m_err = nerr;
    endtask

    // One clock: drive sources, compare against the reference, log, advance.
    task automatic step();
        flit_t         hd;
        logic [OW-1:0] obs, expv;
        logic [N-1:0]  eg;
        bit            ev;
        for (int p = 0; p < N; p++) begin
            drv_valid[p] = (fq[p].size() > 0) && gate[p];
            if (drv_valid[p]) begin
                hd = fq[p][0];
                bus.in_flit_data[p*32 +: 32] = hd.data;
                bus.in_flit_last[p]          = hd.last;
                bus.in_flit_16[p]            = hd.f16;
            end else begin
                bus.in_flit_data[p*32 +: 32] = $urandom;
                bus.in_flit_last[p]          = 1'($urandom);
                bus.in_flit_16[p]            = 1'($urandom);
            end
        end
        bus.in_flit_valid  = drv_valid;
        bus.out_flit_ready = ready_drv;
        rst                = rst_drv;
        #1;
        eg = '0;
        exp_rdy = '0;
        if (m_busy) begin
            eg[m_owner]      = 1'b1;
            exp_rdy[m_owner] = m_drop ? 1'b1 : ready_drv;
        end
        ev = m_busy && !m_drop && drv_valid[m_owner];
        hd = '0;
        if (ev) hd = fq[m_owner][0];
        expv = {eg, exp_rdy, ev, hd.data, hd.last | (ev && m_cnt == MAXL - 1), hd.f16, m_err};
        obs  = {bus.grant, bus.in_flit_ready, bus.out_flit_valid,
                bus.out_flit_valid ? bus.out_flit_data : 32'd0,
                bus.out_flit_valid & bus.out_flit_last, bus.out_flit_valid & bus.out_flit_16,
                bus.err_overlen};
        if (obs !== expv) begin
            if (cyc_mism == 0) begin
                first_obs = obs; first_exp = expv; first_t = $time;
            end
            cyc_mism++;
        end
        if (bus.out_flit_valid === 1'b1 && ready_drv) begin
            seen.push_back({bus.out_flit_data, bus.out_flit_last, bus.out_flit_16});
            for (int p = 0; p < N; p++) if (bus.grant[p] === 1'b1) seen_port.push_back(p);
        end
        if (bus.err_overlen === 1'b1) err_cnt++;
        if (prev_grant == '0 && bus.grant != '0) grant_log.push_back(bus.grant);
        prev_grant = bus.grant;
        @(posedge clk);
        advance();
        #1;
    endtask

    function automatic bit pending();
        for (int p = 0; p < N; p++) if (fq[p].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    // Run with all sources and the sink open until every queued flit is gone.
    task automatic drain(input int max_steps);
        drain_to    = 1'b0;
        drain_steps = 0;
        gate        = '1;
        ready_drv   = 1'b1;
        while (pending() || m_busy) begin
            if (drain_steps >= max_steps) begin
                drain_to = 1'b1;
                break;
            end
            step();
            drain_steps++;
        end
    endtask

    // Number of discrepancies between observed and expected per-port streams.
    function automatic int stream_bad();
        int bad;
        int idx [N];
        bad = (seen.size() != seen_port.size()) ? 1 : 0;
        for (int p = 0; p < N; p++) idx[p] = 0;
        for (int i = 0; i < seen.size() && i < seen_port.size(); i++) begin
            if (idx[seen_port[i]] >= exp_pp[seen_port[i]].size()) bad++;
            else if (seen[i] !== exp_pp[seen_port[i]][idx[seen_port[i]]]) bad++;
            idx[seen_port[i]]++;
        end
        for (int p = 0; p < N; p++) if (idx[p] != exp_pp[p].size()) bad++;
        return bad;
    endfunction

    task automatic do_reset();
        for (int p = 0; p < N; p++) begin
            fq[p].delete();
            exp_pp[p].delete();
        end
        gate = '0; ready_drv = 1'b0; rst_drv = 1'b1;
        step(); step();
        rst_drv = 1'b0;
        clear_logs();
    endtask

    task automatic test_reset();
        for (int p = 0; p < N; p++) begin fq[p].delete(); exp_pp[p].delete(); end
        rst_drv = 1'b1; gate = '1; ready_drv = 1'b1;
        push_pkt(0, 3, 32'h1111_1111, 32'h1111_1111, 32'd0);
        step();
        clear_logs();
        step(); step();
        checks++;
        if (cyc_mism !== 0) $display("FAIL reset_hold: obs=%h exp=%h at %0t", first_obs, first_exp, first_t);
        else passed++;
        checks++;
        if ({bus.grant, bus.in_flit_ready, bus.out_flit_valid, bus.out_flit_last, bus.out_flit_16, bus.err_overlen} !== '0)
            $display("FAIL reset_outputs: grant=%b ready=%b valid=%b last=%b f16=%b err=%b, want all 0",
                     bus.grant, bus.in_flit_ready, bus.out_flit_valid, bus.out_flit_last, bus.out_flit_16, bus.err_overlen);
        else passed++;
        rst_drv = 1'b0;
        step();
        checks++;
        if (bus.grant !== 2'b01) $display("FAIL reset_first_grant: grant=%b want 01", bus.grant);
        else passed++;
    endtask

    task automatic test_basic();
        do_reset();
        push_pkt(0, 3, 32'h1111_1111, 32'h1111_1111, 32'd0);
        gate = '1; ready_drv = 1'b1;
        repeat (6) step();
        checks++;
        if (cyc_mism !== 0) $display("FAIL basic_cycle: obs=%h exp=%h at %0t", first_obs, first_exp, first_t);
        else passed++;
        checks++;
        if (seen.size() !== 3 || seen[0] !== {32'h1111_1111, 1'b0, 1'b0} || seen[1] !== {32'h2222_2222, 1'b0, 1'b0}
            || seen[2] !== {32'h3333_3333, 1'b1, 1'b0})
            $display("FAIL basic_stream: got %0d flits (first %h), want 3 flits 11111111/22222222/33333333 last on third",
                     seen.size(), (seen.size() > 0) ? seen[0].data : 32'd0);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int bad;
        do_reset();
        for (int k = 0; k < 3; k++)
            for (int p = 0; p < N; p++) push_pkt(p, 2, 32'hA000_0000 + 32'(p * 256 + k * 16), 32'd1, 32'd0);
        drain(80);
        checks++;
        if (cyc_mism !== 0 || drain_to) $display("FAIL b2b_cycle: mism=%0d timeout=%0d obs=%h exp=%h", cyc_mism, drain_to, first_obs, first_exp);
        else passed++;
        bad = (grant_log.size() != 6) ? 1 : 0;
        for (int i = 0; i < grant_log.size(); i++) if (grant_log[i] !== ((i % 2 == 0) ? 2'b01 : 2'b10)) bad++;
        checks++;
        if (bad !== 0) $display("FAIL b2b_alternate: %0d grant-order errors over %0d grants, want 0 over 6", bad, grant_log.size());
        else passed++;
        checks++;
        if (stream_bad() !== 0) $display("FAIL b2b_stream: %0d stream errors, want 0", stream_bad());
        else passed++;
        checks++;
        if (drain_steps !== 18) $display("FAIL b2b_throughput: %0d cycles for 6 two-flit packets, want 18", drain_steps);
        else passed++;
    endtask

    task automatic test_ready_toggle();
        int bad;
        do_reset();
        push_pkt(1, 4, 32'hB000_0000, 32'd3, 32'd0);
        gate = '1; ready_drv = 1'b1;
        step();
        push_pkt(0, 2, 32'hC000_0000, 32'd5, 32'd0);
        for (int k = 0; k < 12; k++) begin
            ready_drv = (k % 2 == 0);
            step();
        end
        drain(40);
        checks++;
        if (cyc_mism !== 0 || drain_to) $display("FAIL toggle_cycle: mism=%0d timeout=%0d obs=%h exp=%h", cyc_mism, drain_to, first_obs, first_exp);
        else passed++;
        checks++;
        if (stream_bad() !== 0) $display("FAIL toggle_stream: %0d stream errors, want 0", stream_bad());
        else passed++;
        bad = (grant_log.size() != 2) ? 1 : 0;
        if (grant_log.size() == 2 && (grant_log[0] !== 2'b10 || grant_log[1] !== 2'b01)) bad++;
        checks++;
        if (bad !== 0) $display("FAIL toggle_order: %0d grant-order errors, want port1 then port0", bad);
        else passed++;
    endtask

    task automatic test_overlen(input int len, input int want_err);
        do_reset();
        push_pkt(0, len, 32'hD000_0000, 32'd7, 32'd0);
        drain(60);
        checks++;
        if (cyc_mism !== 0 || drain_to) $display("FAIL len%0d_cycle: mism=%0d timeout=%0d obs=%h exp=%h", len, cyc_mism, drain_to, first_obs, first_exp);
        else passed++;
        checks++;
        if (err_cnt !== want_err) $display("FAIL len%0d_err: %0d err_overlen pulses, want %0d", len, err_cnt, want_err);
        else passed++;
        checks++;
        if (stream_bad() !== 0 || seen.size() !== MAXL) $display("FAIL len%0d_stream: %0d flits forwarded, %0d errors, want %0d flits", len, seen.size(), stream_bad(), MAXL);
        else passed++;
    endtask

    task automatic test_mid_reset();
        do_reset();
        gate = '1; ready_drv = 1'b1;
        push_pkt(0, 1, 32'hE000_0000, 32'd1, 32'd0);
        drain(10);
        push_pkt(1, 4, 32'hE100_0000, 32'd1, 32'd0);
        step(); step();
        rst_drv = 1'b1;
        step();
        checks++;
        if ({bus.grant, bus.in_flit_ready, bus.out_flit_valid, bus.out_flit_last, bus.out_flit_16, bus.err_overlen} !== '0)
            $display("FAIL midrst_outputs: grant=%b ready=%b valid=%b last=%b f16=%b err=%b, want all 0",
                     bus.grant, bus.in_flit_ready, bus.out_flit_valid, bus.out_flit_last, bus.out_flit_16, bus.err_overlen);
        else passed++;
        rst_drv = 1'b0;
        for (int p = 0; p < N; p++) begin fq[p].delete(); exp_pp[p].delete(); end
        clear_logs();
        push_pkt(0, 1, 32'hE200_0000, 32'd1, 32'd0);
        push_pkt(1, 1, 32'hE300_0000, 32'd1, 32'd0);
        drain(20);
        checks++;
        if (grant_log.size() < 1 || grant_log[0] !== 2'b01)
            $display("FAIL midrst_priority: first grant=%b want 01", (grant_log.size() > 0) ? grant_log[0] : 2'b00);
        else passed++;
        checks++;
        if (cyc_mism !== 0 || stream_bad() !== 0) $display("FAIL midrst_after: mism=%0d stream errors=%0d, want 0/0", cyc_mism, stream_bad());
        else passed++;
    endtask

    task automatic test_flit16();
        do_reset();
        push_pkt(1, 3, 32'hF000_0000, 32'd9, 32'b010);
        drain(20);
        checks++;
        if (cyc_mism !== 0) $display("FAIL f16_cycle: obs=%h exp=%h at %0t", first_obs, first_exp, first_t);
        else passed++;
        checks++;
        if (seen.size() !== 3 || {seen[0].f16, seen[1].f16, seen[2].f16} !== 3'b010)
            $display("FAIL f16_marker: %0d flits, markers %b, want 3 flits with 010", seen.size(),
                     (seen.size() == 3) ? {seen[0].f16, seen[1].f16, seen[2].f16} : 3'b000);
        else passed++;
    endtask

    task automatic test_random();
        int len, want_err, want_fwd;
        do_reset();
        want_err = 0; want_fwd = 0;
        for (int k = 0; k < 40; k++) begin
            len = $urandom_range(1, 14);
            want_err += (len > MAXL) ? 1 : 0;
            want_fwd += (len > MAXL) ? MAXL : len;
            push_pkt($urandom_range(0, N - 1), len, $urandom, $urandom | 32'd1, $urandom);
        end
        for (int s = 0; s < 400; s++) begin
            for (int p = 0; p < N; p++) gate[p] = ($urandom_range(0, 3) != 0);
            ready_drv = ($urandom_range(0, 3) != 0);
            step();
        end
        drain(1500);
        checks++;
        if (cyc_mism !== 0 || drain_to) $display("FAIL rand_cycle: mism=%0d timeout=%0d obs=%h exp=%h at %0t", cyc_mism, drain_to, first_obs, first_exp, first_t);
        else passed++;
        checks++;
        if (err_cnt !== want_err) $display("FAIL rand_err: %0d truncations, want %0d", err_cnt, want_err);
        else passed++;
        checks++;
        if (seen.size() !== want_fwd || stream_bad() !== 0) $display("FAIL rand_stream: %0d flits, %0d errors, want %0d flits", seen.size(), stream_bad(), want_fwd);
        else passed++;
    endtask

    initial begin
        checks = 0; passed = 0;
        rst = 1'b1; rst_drv = 1'b1; gate = '0; ready_drv = 1'b0;
        m_busy = 0; m_drop = 0; m_err = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
        bus.in_flit_data = '0; bus.in_flit_valid = '0; bus.in_flit_last = '0;
        bus.in_flit_16 = '0; bus.out_flit_ready = 1'b0;
        clear_logs();
        test_reset();
        test_basic();
        test_back_to_back();
        test_ready_toggle();
        test_overlen(13, 1);
        test_overlen(10, 0);
        test_mid_reset();
        test_flit16();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
